// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor and the status-register block:
// FSM state encoding, default cycle constants and a saturating counter helper.
package pll_lock_supervisor_pkg;

    // 3-bit state encoding; the status-register block decodes these values.
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } sup_state_e;

    // Default timing for a 50 MHz board clock.
    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 5000000;  // 100 ms
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_RST_HOLD_CYC     = 256;
    localparam int DEF_CNT_W            = 23;

    // Event counters stop at 255 so a storm of events never reads as "few".
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level signal.
module cdc_sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the asynchronous input through two flops; both clear to 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset pin, qualifies the asynchronous LOCK output and releases
// the video-domain reset only after lock has been stable for a while. Loss of
// lock in RUN re-arms the PLL; relock and timeout events are counted.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       user_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] relock_cnt,
    output logic [7:0] timeout_cnt
);

    // Terminal timer values: each state lasts exactly N cycles when its timer
    // runs from 0 up to N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);

    sup_state_e       state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             lock_s;
    logic             loss_evt;
    logic             timeout_evt;

    logic             pll_rst_reg;
    logic             user_rst_n_reg;
    logic             ready_reg;
    logic             lock_lost_reg;
    logic [7:0]       relock_cnt_reg;
    logic [7:0]       timeout_cnt_reg;

    cdc_sync_bit u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state and timer logic; a lock drop is checked before any timer
    // terminal or relock request so it always takes priority.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg + 1'b1;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state_reg)
            S_PLL_RST: begin
                if (timer_reg == RST_LAST) begin
                    state_next = S_WAIT_LOCK;
                    timer_next = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = S_STABLE;
                    timer_next = '0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next  = S_PLL_RST;
                    timer_next  = '0;
                    timeout_evt = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = S_HOLD;
                    timer_next = '0;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    state_next = S_PLL_RST;
                    timer_next = '0;
                end else if (timer_reg == HOLD_LAST) begin
                    state_next = S_RUN;
                    timer_next = '0;
                end
            end
            S_RUN: begin
                // Timer is parked at zero here so it cannot wrap during long runs.
                timer_next = '0;
                if (!lock_s) begin
                    state_next = S_PLL_RST;
                    loss_evt   = 1'b1;
                end else if (relock_req) begin
                    state_next = S_PLL_RST;
                end
            end
            default: begin
                state_next = S_PLL_RST;
                timer_next = '0;
            end
        endcase
    end

    // State, timer and registered outputs; outputs are decoded from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= S_PLL_RST;
            timer_reg       <= '0;
            pll_rst_reg     <= 1'b1;
            user_rst_n_reg  <= 1'b0;
            ready_reg       <= 1'b0;
            lock_lost_reg   <= 1'b0;
            relock_cnt_reg  <= 8'd0;
            timeout_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            pll_rst_reg    <= (state_next == S_PLL_RST);
            user_rst_n_reg <= (state_next == S_RUN);
            ready_reg      <= (state_next == S_RUN);
            lock_lost_reg  <= loss_evt;
            if (loss_evt) begin
                relock_cnt_reg <= sat_inc8(relock_cnt_reg);
            end
            if (timeout_evt) begin
                timeout_cnt_reg <= sat_inc8(timeout_cnt_reg);
            end
        end
    end

    assign pll_rst     = pll_rst_reg;
    assign user_rst_n  = user_rst_n_reg;
    assign ready       = ready_reg;
    assign lock_lost   = lock_lost_reg;
    assign relock_cnt  = relock_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;

endmodule
